// File: rtl/gpca_op_sequencer.sv
// Command-side driver for the 9-row gpca array: normalises operands, encodes the
// X/P/B/C/A fields, holds them for the array settle time and returns F/S.
module gpca_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [17:0] cmd_a,
  input  logic [8:0]  cmd_b,
  output logic        X,
  output logic [8:0]  P,
  output logic [18:0] B,
  output logic [18:0] C,
  output logic [17:0] A,
  input  logic [8:0]  F,
  input  logic [18:0] S,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [8:0]  rsp_F,
  output logic [18:0] rsp_S,
  output logic [4:0]  rsp_sh_a,
  output logic [3:0]  rsp_sh_b,
  output logic [1:0]  rsp_op,
  output logic        rsp_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_NORM, ST_DRIVE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL, OP_SQR, OP_SQRT, OP_DIV} op_e;

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [18:0] SQ_B = 19'b0011_1111_1111_1111_111;
  localparam logic [18:0] SQ_C = 19'b0100_0000_0000_0000_000;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [17:0]   a_q, a_d;
  logic [8:0]    b_q, b_d;
  logic [4:0]    sh_a_q, sh_a_d;
  logic [3:0]    sh_b_q, sh_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          x_q, x_d;
  logic [8:0]    p_q, p_d;
  logic [18:0]   b_fld_q, b_fld_d;
  logic [18:0]   c_fld_q, c_fld_d;
  logic [17:0]   a_fld_q, a_fld_d;
  logic [8:0]    rsp_f_q, rsp_f_d;
  logic [18:0]   rsp_s_q, rsp_s_d;
  logic [4:0]    rsp_sh_a_q, rsp_sh_a_d;
  logic [3:0]    rsp_sh_b_q, rsp_sh_b_d;
  logic [1:0]    rsp_op_q, rsp_op_d;
  logic          rsp_err_q, rsp_err_d;
  logic          a_busy, b_busy;

  // An operand keeps shifting while it is nonzero and its MSB is still clear.
  assign a_busy = ((op_q == OP_MUL) || (op_q == OP_DIV)) && !a_q[17] && (a_q != '0);
  assign b_busy = (op_q == OP_DIV) && !b_q[8] && (b_q != '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    p_d        = p_q;
    b_fld_d    = b_fld_q;
    c_fld_d    = c_fld_q;
    a_fld_d    = a_fld_q;
    rsp_f_d    = rsp_f_q;
    rsp_s_d    = rsp_s_q;
    rsp_sh_a_d = rsp_sh_a_q;
    rsp_sh_b_d = rsp_sh_b_q;
    rsp_op_d   = rsp_op_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          a_d     = cmd_a;
          b_d     = cmd_b;
          sh_a_d  = '0;
          sh_b_d  = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (a_busy || b_busy) begin
          if (a_busy) begin
            a_d    = {a_q[16:0], 1'b0};
            sh_a_d = sh_a_q + 5'd1;
          end
          if (b_busy) begin
            b_d    = {b_q[7:0], 1'b0};
            sh_b_d = sh_b_q + 4'd1;
          end
        end else if ((op_q == OP_DIV) && (b_q == '0)) begin
          rsp_f_d    = '0;
          rsp_s_d    = '0;
          rsp_sh_a_d = '0;
          rsp_sh_b_d = '0;
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
        case (op_q)
          OP_MUL: begin
            x_d = 1'b0; p_d = b_q; b_fld_d = {a_q, 1'b0}; c_fld_d = {a_q, 1'b0}; a_fld_d = '0;
          end
          OP_SQR: begin
            x_d = 1'b0; p_d = a_q[8:0]; b_fld_d = SQ_B; c_fld_d = SQ_C; a_fld_d = '0;
          end
          OP_SQRT: begin
            x_d = 1'b1; p_d = '0; b_fld_d = SQ_B; c_fld_d = SQ_C; a_fld_d = a_q;
          end
          default: begin
            x_d = 1'b1; p_d = '0; b_fld_d = {b_q, 10'b0}; c_fld_d = {b_q, 10'b0}; a_fld_d = a_q;
          end
        endcase
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_f_d    = F;
          rsp_s_d    = S;
          rsp_sh_a_d = sh_a_q;
          rsp_sh_b_d = sh_b_q;
          rsp_op_d   = op_q;
          rsp_err_d  = 1'b0;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          x_d     = 1'b0;
          p_d     = '0;
          b_fld_d = '0;
          c_fld_d = '0;
          a_fld_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      cnt_q      <= '0;
      x_q        <= 1'b0;
      p_q        <= '0;
      b_fld_q    <= '0;
      c_fld_q    <= '0;
      a_fld_q    <= '0;
      rsp_f_q    <= '0;
      rsp_s_q    <= '0;
      rsp_sh_a_q <= '0;
      rsp_sh_b_q <= '0;
      rsp_op_q   <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      p_q        <= p_d;
      b_fld_q    <= b_fld_d;
      c_fld_q    <= c_fld_d;
      a_fld_q    <= a_fld_d;
      rsp_f_q    <= rsp_f_d;
      rsp_s_q    <= rsp_s_d;
      rsp_sh_a_q <= rsp_sh_a_d;
      rsp_sh_b_q <= rsp_sh_b_d;
      rsp_op_q   <= rsp_op_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign X         = x_q;
  assign P         = p_q;
  assign B         = b_fld_q;
  assign C         = c_fld_q;
  assign A         = a_fld_q;
  assign rsp_F     = rsp_f_q;
  assign rsp_S     = rsp_s_q;
  assign rsp_sh_a  = rsp_sh_a_q;
  assign rsp_sh_b  = rsp_sh_b_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpca_op_sequencer.sv
// Directed bench for gpca_op_sequencer: field encodings, normalisation shifts,
// latency, DIV-by-zero, mid-operation reset and back-to-back commands.
module tb_gpca_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [17:0] cmd_a;
  logic [8:0]  cmd_b;
  logic        X;
  logic [8:0]  P;
  logic [18:0] B, C;
  logic [17:0] A;
  logic [8:0]  F;
  logic [18:0] S;
  logic        rsp_valid, rsp_ready;
  logic [8:0]  rsp_F;
  logic [18:0] rsp_S;
  logic [4:0]  rsp_sh_a;
  logic [3:0]  rsp_sh_b;
  logic [1:0]  rsp_op;
  logic        rsp_err;

  int checks = 0;
  int fails  = 0;

  localparam logic [18:0] SQ_B = 19'h1FFFF;
  localparam logic [18:0] SQ_C = 19'h20000;

  gpca_op_sequencer #(.SETTLE_CYC(9)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .X(X), .P(P), .B(B), .C(C), .A(A), .F(F), .S(S),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_F(rsp_F), .rsp_S(rsp_S), .rsp_sh_a(rsp_sh_a), .rsp_sh_b(rsp_sh_b),
    .rsp_op(rsp_op), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic send_cmd(input logic [1:0] op, input logic [17:0] a, input logic [8:0] b);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until rsp_valid, and how many of those
  // cycles showed the expected gpca field values.
  task automatic wait_valid(input logic ex, input logic [8:0] ep, input logic [18:0] eb,
                            input logic [18:0] ec, input logic [17:0] ea,
                            output int n, output int held);
    n = 0; held = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if ({X, P, B, C, A} === {ex, ep, eb, ec, ea}) held++;
      if (rsp_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; F = '0; S = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
    checks++;
    if ({X, P, B, C, A} !== '0) begin
      fails++; $display("FAIL reset_fields: got X=%b P=%h B=%h C=%h A=%h expected all 0", X, P, B, C, A);
    end
    checks++;
    if ({rsp_F, rsp_S, rsp_sh_a, rsp_sh_b, rsp_op, rsp_err} !== '0) begin
      fails++; $display("FAIL reset_rsp: got F=%h S=%h sha=%0d shb=%0d op=%0d err=%b expected all 0",
                        rsp_F, rsp_S, rsp_sh_a, rsp_sh_b, rsp_op, rsp_err);
    end
  endtask

  task automatic test_mul;
    int n, held;
    F = 9'h1A5; S = 19'h5A5A5; rsp_ready = 1'b0;
    send_cmd(2'b00, 18'd7, 9'd5);
    wait_valid(1'b0, 9'd5, 19'h70000, 19'h70000, 18'd0, n, held);
    checks++;
    if (n !== 26) begin fails++; $display("FAIL mul_latency: got %0d expected 26", n); end
    checks++;
    if (held !== 10) begin fails++; $display("FAIL mul_fields_held: got %0d cycles expected 10", held); end
    checks++;
    if (rsp_sh_a !== 5'd15 || rsp_sh_b !== 4'd0) begin
      fails++; $display("FAIL mul_shifts: got sha=%0d shb=%0d expected 15 0", rsp_sh_a, rsp_sh_b);
    end
    checks++;
    if ({rsp_op, rsp_err, rsp_F, rsp_S} !== {2'b00, 1'b0, 9'h1A5, 19'h5A5A5}) begin
      fails++; $display("FAIL mul_rsp: got op=%0d err=%b F=%h S=%h expected 0 0 1a5 5a5a5",
                        rsp_op, rsp_err, rsp_F, rsp_S);
    end
    F = '0; S = '0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_F !== 9'h1A5 || rsp_S !== 19'h5A5A5 || P !== 9'd5 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL mul_hold: got valid=%b F=%h S=%h P=%h ready=%b expected 1 1a5 5a5a5 005 0",
                        rsp_valid, rsp_F, rsp_S, P, cmd_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || {X, P, B, C, A} !== '0) begin
      fails++; $display("FAIL mul_release: got valid=%b ready=%b X=%b P=%h B=%h expected 0 1 0 0 0",
                        rsp_valid, cmd_ready, X, P, B);
    end
  endtask

  task automatic test_div;
    int n, held;
    F = 9'h0F3; S = 19'h12345; rsp_ready = 1'b0;
    send_cmd(2'b11, 18'd35, 9'd5);
    wait_valid(1'b1, 9'd0, 19'h50000, 19'h50000, 18'h23000, n, held);
    checks++;
    if (n !== 23) begin fails++; $display("FAIL div_latency: got %0d expected 23", n); end
    checks++;
    if (held !== 10) begin fails++; $display("FAIL div_fields_held: got %0d cycles expected 10", held); end
    checks++;
    if (rsp_sh_a !== 5'd12 || rsp_sh_b !== 4'd6) begin
      fails++; $display("FAIL div_shifts: got sha=%0d shb=%0d expected 12 6", rsp_sh_a, rsp_sh_b);
    end
    checks++;
    if ({rsp_op, rsp_err, rsp_F, rsp_S} !== {2'b11, 1'b0, 9'h0F3, 19'h12345}) begin
      fails++; $display("FAIL div_rsp: got op=%0d err=%b F=%h S=%h expected 3 0 0f3 12345",
                        rsp_op, rsp_err, rsp_F, rsp_S);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL div_release: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_sqrt;
    int n, held;
    F = 9'h005; S = 19'h00A00; rsp_ready = 1'b0;
    send_cmd(2'b10, 18'd25, 9'h1FF);
    wait_valid(1'b1, 9'd0, SQ_B, SQ_C, 18'd25, n, held);
    checks++;
    if (n !== 11) begin fails++; $display("FAIL sqrt_latency: got %0d expected 11", n); end
    checks++;
    if (held !== 10) begin fails++; $display("FAIL sqrt_fields_held: got %0d cycles expected 10", held); end
    checks++;
    if ({rsp_sh_a, rsp_sh_b, rsp_op, rsp_err, rsp_F, rsp_S} !== {5'd0, 4'd0, 2'b10, 1'b0, 9'h005, 19'h00A00}) begin
      fails++; $display("FAIL sqrt_rsp: got sha=%0d shb=%0d op=%0d err=%b F=%h S=%h expected 0 0 2 0 005 00a00",
                        rsp_sh_a, rsp_sh_b, rsp_op, rsp_err, rsp_F, rsp_S);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_div_zero;
    int n, held;
    F = 9'h1FF; S = 19'h7FFFF; rsp_ready = 1'b0;
    send_cmd(2'b11, 18'd35, 9'd0);
    wait_valid(1'b0, 9'd0, 19'd0, 19'd0, 18'd0, n, held);
    checks++;
    if (n !== 13) begin fails++; $display("FAIL divz_latency: got %0d expected 13", n); end
    checks++;
    if (held !== 13) begin fails++; $display("FAIL divz_no_drive: fields zero %0d cycles expected 13", held); end
    checks++;
    if ({rsp_err, rsp_op, rsp_F, rsp_S, rsp_sh_a, rsp_sh_b} !== {1'b1, 2'b11, 9'd0, 19'd0, 5'd0, 4'd0}) begin
      fails++; $display("FAIL divz_rsp: got err=%b op=%0d F=%h S=%h sha=%0d shb=%0d expected 1 3 0 0 0 0",
                        rsp_err, rsp_op, rsp_F, rsp_S, rsp_sh_a, rsp_sh_b);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, cmd_ready, rsp_err, rsp_F, rsp_S} !== {1'b1, 1'b0, 1'b1, 9'd0, 19'd0}) begin
        fails++; $display("FAIL divz_stall%0d: got valid=%b ready=%b err=%b F=%h S=%h expected 1 0 1 0 0",
                          i, rsp_valid, cmd_ready, rsp_err, rsp_F, rsp_S);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL divz_release: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n, held;
    F = 9'h0AA; S = 19'h00555; rsp_ready = 1'b0;
    send_cmd(2'b10, 18'd25, 9'd0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (X !== 1'b1 || A !== 18'd25) begin
      fails++; $display("FAIL rstmid_inflight: got X=%b A=%h expected 1 00019", X, A);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || {X, P, B, C, A} !== '0 ||
        {rsp_F, rsp_S, rsp_sh_a, rsp_sh_b, rsp_op, rsp_err} !== '0) begin
      fails++; $display("FAIL rstmid_clear: got ready=%b valid=%b X=%b A=%h F=%h expected 1 0 0 0 0",
                        cmd_ready, rsp_valid, X, A, rsp_F);
    end
    send_cmd(2'b01, 18'h2A005, 9'h1AB);
    wait_valid(1'b0, 9'd5, SQ_B, SQ_C, 18'd0, n, held);
    checks++;
    if (n !== 11 || held !== 10) begin
      fails++; $display("FAIL sqr_timing: got latency=%0d held=%0d expected 11 10", n, held);
    end
    checks++;
    if ({rsp_op, rsp_err, rsp_sh_a, rsp_sh_b, rsp_F, rsp_S} !== {2'b01, 1'b0, 5'd0, 4'd0, 9'h0AA, 19'h00555}) begin
      fails++; $display("FAIL sqr_rsp: got op=%0d err=%b sha=%0d shb=%0d F=%h S=%h expected 1 0 0 0 0aa 00555",
                        rsp_op, rsp_err, rsp_sh_a, rsp_sh_b, rsp_F, rsp_S);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n, held;
    F = 9'h011; S = 19'h00022; rsp_ready = 1'b1;
    cmd_op = 2'b00; cmd_a = 18'h20000; cmd_b = 9'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    wait_valid(1'b0, 9'd3, 19'h40000, 19'h40000, 18'd0, n, held);
    checks++;
    if (n !== 11 || held !== 10) begin
      fails++; $display("FAIL b2b_first: got latency=%0d held=%0d expected 11 10", n, held);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_handshake: got valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_second_accept: got ready=%b expected 0", cmd_ready);
    end
    wait_valid(1'b0, 9'd3, 19'h40000, 19'h40000, 18'd0, n, held);
    checks++;
    if (n !== 11 || rsp_sh_a !== 5'd0 || rsp_F !== 9'h011) begin
      fails++; $display("FAIL b2b_second: got latency=%0d sha=%0d F=%h expected 11 0 011", n, rsp_sh_a, rsp_F);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_release: got ready=%b valid=%b expected 1 0", cmd_ready, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_sqrt();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
